// File: rtl/wb_switches_pkg.sv
// Shared constants for the switch/button Wishbone slave: register word offsets,
// input count and field widths.
package wb_switches_pkg;

  localparam int unsigned NIn      = 8;
  localparam int unsigned AdrW     = 32;
  localparam int unsigned DatW     = 32;
  localparam int unsigned SelW     = DatW / 8;
  localparam int unsigned DebW     = 20;
  localparam int unsigned IrqEnW   = 16;
  localparam int unsigned CntW     = 3;
  localparam int unsigned WordIdxW = 10;

  // Word indices taken from adr[11:2]
  localparam logic [WordIdxW-1:0] REG_DATA     = 10'h000;
  localparam logic [WordIdxW-1:0] REG_RAW      = 10'h001;
  localparam logic [WordIdxW-1:0] REG_RISE     = 10'h002;
  localparam logic [WordIdxW-1:0] REG_FALL     = 10'h003;
  localparam logic [WordIdxW-1:0] REG_IRQ_EN   = 10'h004;
  localparam logic [WordIdxW-1:0] REG_DEBOUNCE = 10'h005;

endpackage

// File: rtl/wb_switches_if.sv
// Pipelined Wishbone bus bundle used by the switch slave.
interface wb_switches_if;
  import wb_switches_pkg::*;

  logic            cyc;
  logic            stb;
  logic            we;
  logic [AdrW-1:0] adr;
  logic [SelW-1:0] sel;
  logic [DatW-1:0] dat_m;
  logic [DatW-1:0] dat_s;
  logic            ack;
  logic            err;
  logic            stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, err, stall
  );

endinterface

// File: rtl/debounce_bit.sv
// One input lane: 2-flop synchroniser followed by a tick-driven stability counter.
module debounce_bit
  import wb_switches_pkg::*;
#(
  parameter int unsigned StableTicks = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic d,
  output logic sync,
  output logic q
);

  logic            meta;
  logic [CntW-1:0] cnt;

  // Accept sync only after it has differed from q for StableTicks ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      q    <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      if (sync == q) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CntW'(StableTicks - 1)) begin
          q   <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + CntW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/wb_switches.sv
// Wishbone slave exposing debounced switches/buttons, W1C edge capture and a
// level interrupt built from the enabled captured edges.
module wb_switches
  import wb_switches_pkg::*;
#(
  parameter logic [DebW-1:0] DebounceDefault = 20'd100000,
  parameter int unsigned     StableTicks     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_switches_if.slave        wb,
  input  logic [3:0]          sw,
  input  logic [3:0]          btn,
  output logic                irq
);

  logic [NIn-1:0]      pins_c;
  logic [NIn-1:0]      sync_v;
  logic [NIn-1:0]      deb;
  logic [NIn-1:0]      deb_prev;
  logic [NIn-1:0]      rise;
  logic [NIn-1:0]      fall;
  logic [IrqEnW-1:0]   irq_en;
  logic [DebW-1:0]     debounce;
  logic [DebW-1:0]     presc;

  logic                tick_c;
  logic                accept_c;
  logic                wr_c;
  logic [WordIdxW-1:0] word_c;
  logic [DatW-1:0]     rdata_c;
  logic [NIn-1:0]      rise_clr_c;
  logic [NIn-1:0]      fall_clr_c;
  logic                deb_wr_c;
  logic                en_wr_c;
  logic [DebW-1:0]     debounce_wr_c;
  logic [IrqEnW-1:0]   irq_en_wr_c;
  logic                irq_nxt_c;
  logic                unused_bus_c;

  assign pins_c       = {btn, sw};
  assign tick_c       = (presc == debounce);
  assign accept_c     = wb.cyc & wb.stb;
  assign wr_c         = accept_c & wb.we;
  assign word_c       = wb.adr[11:2];
  assign deb_wr_c     = wr_c && (word_c == REG_DEBOUNCE);
  assign en_wr_c      = wr_c && (word_c == REG_IRQ_EN);
  assign rise_clr_c   = (wr_c && word_c == REG_RISE && wb.sel[0]) ? wb.dat_m[NIn-1:0] : '0;
  assign fall_clr_c   = (wr_c && word_c == REG_FALL && wb.sel[0]) ? wb.dat_m[NIn-1:0] : '0;
  assign irq_nxt_c    = (|(rise & irq_en[NIn-1:0])) | (|(fall & irq_en[IrqEnW-1:NIn]));
  assign unused_bus_c = ^{wb.adr[AdrW-1:12], wb.adr[1:0], wb.dat_m[DatW-1:DebW], wb.sel[SelW-1]};

  assign wb.stall = 1'b0;
  assign wb.err   = 1'b0;

  for (genvar i = 0; i < NIn; i++) begin : g_deb
    debounce_bit #(.StableTicks(StableTicks)) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick_c),
      .d    (pins_c[i]),
      .sync (sync_v[i]),
      .q    (deb[i])
    );
  end

  // Byte-lane merge for the RW registers
  always_comb begin
    debounce_wr_c = debounce;
    irq_en_wr_c   = irq_en;
    if (wb.sel[0]) begin
      debounce_wr_c[7:0] = wb.dat_m[7:0];
      irq_en_wr_c[7:0]   = wb.dat_m[7:0];
    end
    if (wb.sel[1]) begin
      debounce_wr_c[15:8] = wb.dat_m[15:8];
      irq_en_wr_c[15:8]   = wb.dat_m[15:8];
    end
    if (wb.sel[2]) begin
      debounce_wr_c[DebW-1:16] = wb.dat_m[DebW-1:16];
    end
  end

  // Read mux; sel is ignored on reads
  always_comb begin
    rdata_c = '0;
    case (word_c)
      REG_DATA:     rdata_c = DatW'(deb);
      REG_RAW:      rdata_c = DatW'(sync_v);
      REG_RISE:     rdata_c = DatW'(rise);
      REG_FALL:     rdata_c = DatW'(fall);
      REG_IRQ_EN:   rdata_c = DatW'(irq_en);
      REG_DEBOUNCE: rdata_c = DatW'(debounce);
      default:      rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      debounce  <= DebounceDefault;
      irq_en    <= '0;
      deb_prev  <= '0;
      rise      <= '0;
      fall      <= '0;
      irq       <= 1'b0;
      wb.ack    <= 1'b0;
      wb.dat_s  <= '0;
    end else begin
      presc <= (tick_c || deb_wr_c) ? '0 : presc + DebW'(1);
      if (deb_wr_c) debounce <= debounce_wr_c;
      if (en_wr_c)  irq_en   <= irq_en_wr_c;
      deb_prev <= deb;
      // A new edge in the same cycle as a W1C keeps the bit set
      rise     <= (rise & ~rise_clr_c) | (deb & ~deb_prev);
      fall     <= (fall & ~fall_clr_c) | (~deb & deb_prev);
      irq      <= irq_nxt_c;
      wb.ack   <= accept_c;
      wb.dat_s <= (accept_c && !wb.we) ? rdata_c : '0;
    end
  end

endmodule

// File: tb/tb_wb_switches.sv
// Directed bench for wb_switches: bus reads/writes scored through an expected-data queue.
module tb_wb_switches;
  import wb_switches_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [3:0] btn = 4'h0;
  logic       irq;

  wb_switches_if wb();

  wb_switches #(.DebounceDefault(20'd100000), .StableTicks(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (wb),
    .sw   (sw),
    .btn  (btn),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        exp_ack = 1'b0;
  bit          mon_en = 1'b0;

  localparam logic [11:0] A_DATA = 12'h000, A_RAW = 12'h004, A_RISE = 12'h008,
                          A_FALL = 12'h00C, A_EN = 12'h010, A_DEB = 12'h014, A_HOLE = 12'h018;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every accepted request must be acked exactly one cycle later
  always @(posedge clk) exp_ack <= rst_n & wb.cyc & wb.stb;

  always @(negedge clk) begin
    if (mon_en) begin
      check(32'(wb.ack), 32'(exp_ack), "ack_timing");
      check(32'({wb.stall, wb.err}), 32'd0, "stall_err");
      if (wb.ack) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL ack_unexpected: observed ack with empty scoreboard, expected no ack");
        end
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          string       t;
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          check(wb.dat_s, e, t);
        end
      end else begin
        check(wb.dat_s, 32'd0, "dat_s_idle");
      end
    end
  end

  task automatic issue(input logic we, input logic [11:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string tag);
    wb.cyc   = 1'b1;
    wb.stb   = 1'b1;
    wb.we    = we;
    wb.adr   = 32'(adr);
    wb.dat_m = dat;
    wb.sel   = sel;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] adr, input logic [31:0] exp, input string tag);
    issue(1'b0, adr, 32'd0, 4'h0, exp, tag);
  endtask

  task automatic wr(input logic [11:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                    input string tag);
    issue(1'b1, adr, dat, sel, 32'd0, tag);
  endtask

  task automatic idle(input int n);
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    wb.we  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.adr = '0; wb.sel = '0; wb.dat_m = '0;
    repeat (3) @(negedge clk);
    check(32'(irq), 32'd0, "irq_in_reset");
    check(32'(wb.ack), 32'd0, "ack_in_reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Reset values
    rd(A_DEB, 32'd100000, "rst_debounce");
    rd(A_DATA, 32'd0, "rst_data");
    rd(A_EN, 32'd0, "rst_irq_en");
    rd(A_RISE, 32'd0, "rst_rise");
    idle(1);
    check(32'(irq), 32'd0, "rst_irq");

    // Byte enables on a write: only the low byte of DEBOUNCE changes
    wr(A_DEB, 32'hFFFF_FFFF, 4'b0001, "wr_deb_byte");
    idle(1);
    rd(A_DEB, 32'h0001_86FF, "deb_byte_lane");
    wr(A_DEB, 32'd1, 4'b1111, "wr_deb_1");
    idle(1);

    // Debounce pass, DEBOUNCE=1: accepted after 9 or 10 edges
    sw = 4'h1;
    idle(8);
    rd(A_DATA, 32'd0, "deb_not_before_9");
    idle(1);
    rd(A_DATA, 32'h01, "deb_by_10");
    idle(2);
    rd(A_RISE, 32'h01, "rise_sw0");
    rd(A_FALL, 32'h00, "fall_after_rise");
    rd(A_RAW, 32'h01, "raw_sw0");

    // Glitch: btn[1] high for 3 cycles
    btn = 4'b0010;
    idle(2);
    rd(A_RAW, 32'h21, "raw_glitch_pulse");
    btn = 4'b0000;
    idle(20);
    rd(A_DATA, 32'h01, "glitch_data");
    rd(A_RISE, 32'h01, "glitch_rise");
    rd(A_FALL, 32'h00, "glitch_fall");
    rd(A_RAW, 32'h01, "raw_after_glitch");

    // Interrupt on falling sw[0], then W1C
    wr(A_EN, 32'h0000_0100, 4'b0011, "wr_irq_en");
    wr(A_RISE, 32'h0000_00FF, 4'b0001, "w1c_rise_all");
    idle(1);
    check(32'(irq), 32'd0, "irq_quiet");
    sw = 4'h0;
    idle(14);
    rd(A_FALL, 32'h01, "fall_sw0");
    check(32'(irq), 32'd1, "irq_on_fall");
    wr(A_FALL, 32'h01, 4'b0001, "w1c_fall");
    check(32'(irq), 32'd1, "irq_one_cycle_after");
    idle(1);
    check(32'(irq), 32'd0, "irq_cleared");
    rd(A_FALL, 32'h00, "fall_cleared");

    // Set/clear race, DEBOUNCE=0: RISE set lands on edge 7 after the pin change
    wr(A_DEB, 32'd0, 4'b0111, "wr_deb_0");
    idle(2);
    sw = 4'h1;
    idle(6);
    wr(A_RISE, 32'h01, 4'b0001, "w1c_race");
    rd(A_RISE, 32'h01, "race_set_wins");
    wr(A_RISE, 32'h01, 4'b0001, "w1c_rise");
    rd(A_RISE, 32'h00, "rise_cleared");
    check(32'(irq), 32'd0, "irq_masked_rise");

    // Pipelined reads incl. unmapped, then ignored write to a hole
    rd(A_DATA, 32'h01, "pipe_data");
    rd(A_HOLE, 32'h00, "pipe_hole");
    rd(A_RAW, 32'h01, "pipe_raw");
    wr(A_HOLE, 32'hFFFF_FFFF, 4'hF, "wr_hole");
    idle(1);
    rd(A_EN, 32'h0000_0100, "hole_irq_en");
    rd(A_DEB, 32'd0, "hole_debounce");
    rd(A_RISE, 32'h00, "hole_rise");

    idle(3);
    check(32'(exp_q.size()), 32'd0, "scoreboard_drained");
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
